// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared encodings for the immediate-extension stage.
// Extension modes as carried on in_mode and the prefix FSM states.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        IMM_SEXT      = 2'b00,
        IMM_ZEXT      = 2'b01,
        IMM_SEXT_SHR1 = 2'b10,
        IMM_PREFIX    = 2'b11
    } imm_mode_e;

    typedef enum logic {
        PFX_IDLE    = 1'b0,
        PFX_PENDING = 1'b1
    } pfx_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: purely combinational extension of a right-aligned value of
// run-time width src_w up to OUT_W bits. PREFIX mode extends like ZEXT, which
// is what the stage needs whenever prefixing is compiled out.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int SW_W  = $clog2(OUT_W + 1)
) (
    input  logic [OUT_W-1:0] value,
    input  logic [SW_W-1:0]  src_w,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] result
);

    // Extend v from bit w-1; fill with that bit when do_sign is set, else zeros.
    function automatic logic [OUT_W-1:0] extend(input logic [OUT_W-1:0] v,
                                                 input int w,
                                                 input logic do_sign);
        logic             sgn;
        logic [OUT_W-1:0] r;
        sgn = 1'b0;
        r   = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (i == w - 1) sgn = v[i];
        end
        for (int i = 0; i < OUT_W; i++) begin
            r[i] = (i < w) ? v[i] : (do_sign & sgn);
        end
        return r;
    endfunction

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;

    assign w_sext = extend(value, int'(src_w), 1'b1);
    assign w_zext = extend(value, int'(src_w), 1'b0);

    // Select the extension; SHR1 is an arithmetic shift of the sign-extended value.
    always_comb begin
        result = w_zext;
        case (imm_mode_e'(mode))
            IMM_SEXT:      result = w_sext;
            IMM_ZEXT:      result = w_zext;
            IMM_SEXT_SHR1: result = {w_sext[OUT_W-1], w_sext[OUT_W-1:1]};
            default:       result = w_zext;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate-extension stage with valid/ready
// handshake. Define IMM_EXT_PREFIX_EN to build the immediate-prefix register
// and PENDING state; without it mode 11 is a plain zero-extension.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 6,
    parameter int OUT_W = 16,
    parameter int PFX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [PFX_W-1:0] pfx_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic             out_pfx_used
);

    localparam int SW_W = $clog2(OUT_W + 1);

    if (IN_W + PFX_W > OUT_W) begin : g_bad_widths
        $error("imm_ext_pipe: IN_W + PFX_W must not exceed OUT_W");
    end

    logic             r_vld_p1;
    logic [OUT_W-1:0] r_imm_p1;
    logic             r_pfx_used_p1;

    logic             w_in_fire;
    logic             w_load;
    logic [OUT_W-1:0] w_value;
    logic [SW_W-1:0]  w_src_w;
    logic [OUT_W-1:0] w_result;
    logic             w_use_pfx;

    assign in_ready  = !flush && (!r_vld_p1 || out_ready);
    assign w_in_fire = in_valid && in_ready;

`ifdef IMM_EXT_PREFIX_EN
    pfx_state_e       r_pfx_state;
    pfx_state_e       w_pfx_next;
    logic [PFX_W-1:0] r_pfx_reg;
    logic             w_is_pfx;

    assign w_is_pfx  = (imm_mode_e'(in_mode) == IMM_PREFIX);
    assign w_use_pfx = (r_pfx_state == PFX_PENDING);
    assign w_load    = w_in_fire && !w_is_pfx;
    assign w_src_w   = w_use_pfx ? SW_W'(IN_W + PFX_W) : SW_W'(IN_W);

    // Prefix FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_pfx_state <= PFX_IDLE;
        else        r_pfx_state <= w_pfx_next;
    end

    // Prefix FSM next state: flush wins, then any accepted instruction.
    always_comb begin
        w_pfx_next = r_pfx_state;
        if (flush) begin
            w_pfx_next = PFX_IDLE;
        end else if (w_in_fire) begin
            w_pfx_next = w_is_pfx ? PFX_PENDING : PFX_IDLE;
        end
    end

    // Capture prefix bits on every accepted PREFIX; a later PREFIX overwrites.
    always_ff @(posedge clk) begin
        if (!rst_n)                     r_pfx_reg <= '0;
        else if (w_in_fire && w_is_pfx) r_pfx_reg <= pfx_in;
    end

    // Right-align the source, with the prefix above the immediate when pending.
    always_comb begin
        w_value = '0;
        w_value[IN_W-1:0] = in_imm;
        if (w_use_pfx) w_value[IN_W+PFX_W-1:IN_W] = r_pfx_reg;
    end
`else
    logic w_unused_pfx;

    assign w_unused_pfx = ^pfx_in;
    assign w_use_pfx    = 1'b0;
    assign w_load       = w_in_fire;
    assign w_src_w      = SW_W'(IN_W);

    // Right-align the immediate; no prefix path exists in this build.
    always_comb begin
        w_value = '0;
        w_value[IN_W-1:0] = in_imm;
    end
`endif

    imm_ext_core #(
        .OUT_W (OUT_W),
        .SW_W  (SW_W)
    ) u_core (
        .value  (w_value),
        .src_w  (w_src_w),
        .mode   (in_mode),
        .result (w_result)
    );

    // Stage p0 -> p1: output register; load on a non-prefix transfer, drop on consume.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_vld_p1      <= 1'b0;
            r_imm_p1      <= '0;
            r_pfx_used_p1 <= 1'b0;
        end else if (w_load) begin
            r_vld_p1      <= 1'b1;
            r_imm_p1      <= w_result;
            r_pfx_used_p1 <= w_use_pfx;
        end else if (out_ready) begin
            r_vld_p1      <= 1'b0;
        end
    end

    assign out_valid    = r_vld_p1;
    assign out_imm      = r_imm_p1;
    assign out_pfx_used = r_pfx_used_p1;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed bench for imm_ext_pipe at default parameters.
// Prefix scenarios are selected by IMM_EXT_PREFIX_EN to match the build.
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_imm;
    logic [1:0]  in_mode;
    logic [9:0]  pfx_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic        out_pfx_used;

    int n_cmp = 0;
    int n_err = 0;

    imm_ext_pipe #(.IN_W(6), .OUT_W(16), .PFX_W(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_imm       (in_imm),
        .in_mode      (in_mode),
        .pfx_in       (pfx_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_imm      (out_imm),
        .out_pfx_used (out_pfx_used)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle input beat, then release in_valid; output is checked afterwards.
    task automatic send(input logic [5:0] imm, input logic [1:0] mode, input logic [9:0] pfx);
        in_imm   = imm;
        in_mode  = mode;
        pfx_in   = pfx;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [15:0] val, input logic used);
        check({tag, "_vld"}, 16'(out_valid), 16'h1);
        check({tag, "_imm"}, out_imm, val);
        check({tag, "_used"}, 16'(out_pfx_used), 16'(used));
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_imm    = 6'h25;
        in_mode   = IMM_SEXT;
        pfx_in    = 10'h0;
        out_ready = 1'b1;

        // Reset with in_valid asserted
        tick();
        tick();
        check("rst_vld", 16'(out_valid), 16'h0);
        check("rst_imm", out_imm, 16'h0000);
        check("rst_used", 16'(out_pfx_used), 16'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("idle_vld", 16'(out_valid), 16'h0);
        check("idle_rdy", 16'(in_ready), 16'h1);

        // Basic modes
        send(6'h25, IMM_SEXT, 10'h0);
        expect_beat("sext25", 16'hFFE5, 1'b0);
        send(6'h25, IMM_ZEXT, 10'h0);
        expect_beat("zext25", 16'h0025, 1'b0);
        send(6'h25, IMM_SEXT_SHR1, 10'h0);
        expect_beat("shr25", 16'hFFF2, 1'b0);
        send(6'h05, IMM_SEXT, 10'h0);
        expect_beat("sext05", 16'h0005, 1'b0);
        tick();
        check("drain_vld", 16'(out_valid), 16'h0);

        // Back-to-back throughput
        in_valid = 1'b1;
        in_imm   = 6'h3A;
        in_mode  = IMM_ZEXT;
        tick();
        check("b2b0_imm", out_imm, 16'h003A);
        in_imm  = 6'h21;
        in_mode = IMM_SEXT;
        tick();
        check("b2b1_imm", out_imm, 16'hFFE1);
        check("b2b1_vld", 16'(out_valid), 16'h1);
        in_valid = 1'b0;
        tick();

        // Backpressure
        out_ready = 1'b0;
        send(6'h3A, IMM_ZEXT, 10'h0);
        expect_beat("bp_first", 16'h003A, 1'b0);
        in_valid = 1'b1;
        in_imm   = 6'h11;
        in_mode  = IMM_ZEXT;
        for (int i = 0; i < 3; i++) begin
            check("bp_rdy", 16'(in_ready), 16'h0);
            tick();
            check("bp_hold", out_imm, 16'h003A);
            check("bp_vld", 16'(out_valid), 16'h1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_rdy", 16'(in_ready), 16'h1);
        tick();
        in_valid = 1'b0;
        expect_beat("bp_queued", 16'h0011, 1'b0);
        tick();
        check("bp_nodup", 16'(out_valid), 16'h0);

`ifdef IMM_EXT_PREFIX_EN
        // Prefix widens the next immediate
        send(6'h00, IMM_PREFIX, 10'h3FF);
        check("pfx_nobeat", 16'(out_valid), 16'h0);
        send(6'h01, IMM_ZEXT, 10'h0);
        expect_beat("pfx_zext", 16'hFFC1, 1'b1);
        send(6'h01, IMM_ZEXT, 10'h0);
        expect_beat("pfx_after", 16'h0001, 1'b0);
        send(6'h00, IMM_PREFIX, 10'h3FF);
        send(6'h00, IMM_PREFIX, 10'h200);
        send(6'h02, IMM_SEXT_SHR1, 10'h0);
        expect_beat("pfx_shr", 16'hC001, 1'b1);
        tick();

        // Flush drops the pending prefix and refuses input
        send(6'h00, IMM_PREFIX, 10'h155);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_imm   = 6'h3F;
        in_mode  = IMM_SEXT;
        #1;
        check("fl_rdy", 16'(in_ready), 16'h0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_vld", 16'(out_valid), 16'h0);
        send(6'h3F, IMM_SEXT, 10'h0);
        expect_beat("fl_next", 16'hFFFF, 1'b0);
        tick();
`else
        // Mode 11 is a zero-extending beat without the prefix feature
        send(6'h2A, IMM_PREFIX, 10'h3FF);
        expect_beat("m11_2a", 16'h002A, 1'b0);
        send(6'h25, IMM_PREFIX, 10'h155);
        expect_beat("m11_25", 16'h0025, 1'b0);
        tick();

        // Flush clears a held output and refuses input
        out_ready = 1'b0;
        send(6'h15, IMM_ZEXT, 10'h0);
        expect_beat("fl_pre", 16'h0015, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_imm   = 6'h3F;
        in_mode  = IMM_SEXT;
        #1;
        check("fl_rdy", 16'(in_ready), 16'h0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("fl_vld", 16'(out_valid), 16'h0);
        check("fl_imm", out_imm, 16'h0000);
        send(6'h3F, IMM_SEXT, 10'h0);
        expect_beat("fl_next", 16'hFFFF, 1'b0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, registered immediate-extension stage sitting between instruction decode and the ALU operand mux. Accepts an IN_W-bit immediate field plus a 2-bit extension mode, produces an OUT_W-bit operand one cycle later behind a valid/ready handshake. It also holds an optional immediate prefix: a dedicated prefix instruction supplies upper bits that widen the next immediate.

## Interface
Parameters:
- IN_W, 6, immediate field width from the instruction word
- OUT_W, 16, datapath / operand width
- PFX_W, 10, prefix width; IN_W+PFX_W <= OUT_W is required (elaboration error otherwise)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  pipeline flush; clears pending prefix and the output register
- in_valid  in  1  input transfer request
- in_ready  out  1  stage can accept input
- in_imm  in  IN_W  raw immediate field
- in_mode  in  2  00 SEXT, 01 ZEXT, 10 SEXT_SHR1, 11 PREFIX
- pfx_in  in  PFX_W  prefix bits, sampled only when in_mode=11
- out_valid  out  1  out_imm holds a valid operand
- out_ready  in  1  consumer accepts operand
- out_imm  out  OUT_W  extended operand
- out_pfx_used  out  1  out_imm was built from a pending prefix

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- in_ready = !flush && (!out_valid || out_ready).
- Extension, for a non-prefixed transfer:
  - SEXT: in_imm[IN_W-1] replicated to OUT_W.
  - ZEXT: zero-filled to OUT_W.
  - SEXT_SHR1: in_imm[IN_W-1:1] sign-extended from in_imm[IN_W-1]; LSB discarded.
- PREFIX (mode 11): latches pfx_in into pfx_reg and sets pfx_pending. No output is produced and the output register is untouched. A second PREFIX while pending overwrites pfx_reg.
- Transfer with pfx_pending=1 and mode != 11:
  - Value is {pfx_reg, in_imm}, IN_W+PFX_W bits. SEXT_SHR1 applies its shift after concatenation.
  - Result is sign-extended (SEXT/SEXT_SHR1) or zero-extended (ZEXT) from bit IN_W+PFX_W-1 to OUT_W.
  - out_pfx_used=1; pfx_pending clears in the same cycle.
- Prefix state machine:
  - IDLE → PENDING on PREFIX transfer.
  - PENDING → IDLE on any non-prefix transfer.
  - PENDING → PENDING on PREFIX.
  - Any state → IDLE on flush.
- flush: out_valid→0 and pfx_pending→0 next edge. in_ready=0 during flush, so same-cycle input is refused, not lost.
- Output held stable while out_valid && !out_ready.

## Timing
- Reset, and flush for valid/pending: out_valid=0, out_imm=0, out_pfx_used=0, pfx_pending=0, pfx_reg=0.
- Latency 1 cycle input→out_valid. Full throughput: one operand per cycle with out_ready held high.
- Simultaneous in and out transfer: new value replaces old at the edge; no bubble.
- PREFIX costs one input cycle and produces no output beat.
- Reset has priority over flush; flush has priority over transfers.

## Configuration
- IMM_EXT_PREFIX_EN defined: prefix register, PENDING state and out_pfx_used are implemented as above.
- Undefined:
  - mode 11 behaves exactly as ZEXT and produces an output beat.
  - pfx_in is ignored.
  - out_pfx_used is tied to 0.
  - No prefix state exists.

## Structure
- Shared package imm_ext_pkg holds:
  - mode encodings IMM_SEXT, IMM_ZEXT, IMM_SEXT_SHR1, IMM_PREFIX
  - prefix state encoding PFX_IDLE, PFX_PENDING
- One combinational sub-module, imm_ext_core:
  - inputs: value, effective source width, mode
  - output: OUT_W result
  - no state
- imm_ext_pipe holds the handshake, output register and prefix FSM.

## Test plan
Defaults: IN_W=6, OUT_W=16, PFX_W=10.
- Reset: rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, out_imm=0x0000, pfx_pending=0.
- Basic modes, out_ready=1:
  - in_imm=0x25, SEXT → 0xFFE5.
  - in_imm=0x25, ZEXT → 0x0025.
  - in_imm=0x25, SEXT_SHR1 → 0xFFF2.
  - in_imm=0x05, SEXT → 0x0005.
- Prefix (macro on):
  - PREFIX pfx_in=0x3FF, then ZEXT in_imm=0x01 → 0xFFC1, out_pfx_used=1.
  - Next ZEXT in_imm=0x01 → 0x0001, out_pfx_used=0.
- Backpressure: out_ready=0 for 3 cycles after a beat → out_imm stable, in_ready=0. Release → queued input appears next cycle with no loss or duplicate.
- Flush:
  - PREFIX 0x155, then flush with in_valid=1 → in_ready=0.
  - Next SEXT in_imm=0x3F → 0xFFFF, out_pfx_used=0.
- Macro off: mode 11 with in_imm=0x2A → 0x002A output beat, out_pfx_used=0.
